// File: rtl/ysyx_24100012_ifu_pkg.sv
// Shared types and constants for the ysyx_24100012 instruction fetch unit.
package ysyx_24100012_ifu_pkg;

   // Fetch FSM states.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_HOLD,
      ST_DROP
   } ifu_state_e;

   // Every instruction is one 32-bit word.
   localparam int INST_BYTES = 4;

   // PC loaded by reset.
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_24100012_ifu_pc.sv
// Architectural PC register: reset load, sequential advance, aligned redirect
// load, and a one-cycle pulse flagging a misaligned redirect target.
module ysyx_24100012_ifu_pc
   import ysyx_24100012_ifu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  advance,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  misalign_err
);

   logic [ADDR_WIDTH-1:0] pc_next;

   // Next PC: a redirect outranks the sequential advance.
   always_comb begin
      // NOTE: default assignment first so no path leaves pc_next unassigned (no latch).
      pc_next = pc;
      if (redirect_valid) begin
         pc_next = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
      end else if (advance) begin
         pc_next = pc + ADDR_WIDTH'(INST_BYTES);
      end
   end

   // PC and misalign flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      if (rst) begin
         pc           <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         pc           <= pc_next;
         misalign_err <= redirect_valid && (redirect_target[1:0] != 2'b00);
      end
   end

endmodule

// File: rtl/ysyx_24100012_ifu.sv
// Instruction fetch unit: issues word fetches at the PC, waits for the
// variable-latency response, holds the instruction for decode, and squashes
// in-flight or held work when execute redirects the PC.
module ysyx_24100012_ifu
   import ysyx_24100012_ifu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] imem_rsp_data,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic                  misalign_err
);

   ifu_state_e            state;
   ifu_state_e            state_next;
   logic                  req_fire;
   logic                  capture;
   logic                  advance;
   logic [ADDR_WIDTH-1:0] pc;

   assign req_fire      = imem_req_valid && imem_req_ready;
   assign capture       = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
   assign advance       = (state == ST_HOLD) && inst_ready;
   assign imem_req_addr = pc;

   ysyx_24100012_ifu_pc #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc (
      .clk             (clk),
      .rst             (rst),
      .advance         (advance),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .pc              (pc),
      .misalign_err    (misalign_err)
   );

   // Next-state selection; a redirect squashes whatever the FSM is doing.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  state_next = ST_FETCH;
         ST_FETCH: begin
            if (req_fire) state_next = redirect_valid ? ST_DROP : ST_WAIT;
         end
         ST_WAIT: begin
            if (redirect_valid) state_next = imem_rsp_valid ? ST_FETCH : ST_DROP;
            else if (imem_rsp_valid) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (redirect_valid || inst_ready) state_next = ST_FETCH;
         end
         ST_DROP: begin
            if (imem_rsp_valid) state_next = ST_FETCH;
         end
         default:  state_next = ST_IDLE;
      endcase
   end

   // FSM state, registered handshake outputs and the instruction buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         imem_req_valid <= 1'b0;
         inst_valid     <= 1'b0;
         inst           <= '0;
         inst_pc        <= '0;
      end else begin
         state          <= state_next;
         imem_req_valid <= (state_next == ST_FETCH);
         inst_valid     <= (state_next == ST_HOLD);
         if (capture) begin
            inst    <= imem_rsp_data;
            inst_pc <= pc;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24100012_ifu.sv
// Directed bench for the instruction fetch unit with a small memory model
// and a scoreboard of instructions expected to be consumed by decode.
module tb_ysyx_24100012_ifu;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        misalign_err;

   int   checks   = 0;
   int   failures = 0;
   exp_t exp_q[$];

   // Memory model state (touched only from the main initial block).
   int          rsp_lat = 1;
   bit          pending = 0;
   int          cnt     = 0;
   logic [31:0] addr_q  = '0;

   ysyx_24100012_ifu dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (inst_valid),
      .inst_ready      (inst_ready),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .misalign_err    (misalign_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h8000_0000) ? 32'h0000_0013 : (a ^ 32'h1357_9BDF);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.inst = mem_data(pc);
      exp_q.push_back(e);
   endtask

   // One clock: score a decode handshake, advance the edge, then update the memory model.
   task automatic cycle();
      exp_t        e;
      logic        acc;
      logic [31:0] acc_addr;
      if (inst_valid === 1'b1 && inst_ready && !redirect_valid && !rst) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL sb_underflow: observed=inst_pc %h expected=no instruction", inst_pc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_inst", inst, e.inst);
            check("sb_pc", inst_pc, e.pc);
         end
      end
      acc      = (imem_req_valid === 1'b1) && imem_req_ready && !rst;
      acc_addr = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rst) pending = 0;
      if (acc) begin
         pending = 1;
         cnt     = rsp_lat;
         addr_q  = acc_addr;
      end
      if (pending) begin
         cnt--;
         if (cnt <= 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(addr_q);
            pending        = 0;
         end
      end
   endtask

   task automatic wait_consumed(input string tag, input int budget);
      int n0;
      n0 = exp_q.size();
      for (int i = 0; i < budget && exp_q.size() == n0; i++) cycle();
      check(tag, exp_q.size(), n0 - 1);
   endtask

   initial begin
      logic [31:0] held_inst;
      rst             = 1'b1;
      imem_req_ready  = 1'b0;
      imem_rsp_valid  = 1'b0;
      imem_rsp_data   = '0;
      inst_ready      = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;

      // Reset state.
      cycle();
      cycle();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      check("rst_misalign", misalign_err, 0);
      check("rst_addr", imem_req_addr, 32'h8000_0000);

      // First request one cycle after reset; memory stalls 5 cycles.
      rst        = 1'b0;
      inst_ready = 1'b1;
      cycle();
      check("first_req_valid", imem_req_valid, 1);
      check("first_req_addr", imem_req_addr, 32'h8000_0000);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("stall_req_valid", imem_req_valid, 1);
         check("stall_req_addr", imem_req_addr, 32'h8000_0000);
         check("stall_inst_valid", inst_valid, 0);
      end

      // Accept, 1-cycle response, consume.
      imem_req_ready = 1'b1;
      push_exp(32'h8000_0000);
      cycle();
      check("wait_req_valid", imem_req_valid, 0);
      cycle();
      check("hold_inst_valid", inst_valid, 1);
      check("hold_inst", inst, 32'h0000_0013);
      check("hold_inst_pc", inst_pc, 32'h8000_0000);
      cycle();
      check("seq_req_valid", imem_req_valid, 1);
      check("seq_req_addr", imem_req_addr, 32'h8000_0004);

      // Redirect in WAIT; stale response 3 cycles after acceptance is dropped.
      rsp_lat = 3;
      cycle();
      check("w_redir_wait", imem_req_valid, 0);
      redirect_valid  = 1'b1;
      redirect_target = 32'h8000_0100;
      cycle();
      redirect_valid = 1'b0;
      check("drop_req_valid", imem_req_valid, 0);
      check("drop_inst_valid", inst_valid, 0);
      check("drop_misalign", misalign_err, 0);
      cycle();
      check("drop2_inst_valid", inst_valid, 0);
      check("drop2_req_valid", imem_req_valid, 0);
      cycle();
      check("after_drop_inst_valid", inst_valid, 0);
      check("after_drop_req_valid", imem_req_valid, 1);
      check("after_drop_addr", imem_req_addr, 32'h8000_0100);

      // Redirect in HOLD together with inst_ready.
      rsp_lat = 1;
      cycle();
      cycle();
      check("h_redir_inst_valid", inst_valid, 1);
      check("h_redir_inst_pc", inst_pc, 32'h8000_0100);
      check("h_redir_inst", inst, mem_data(32'h8000_0100));
      redirect_valid  = 1'b1;
      redirect_target = 32'h8000_0200;
      cycle();
      redirect_valid = 1'b0;
      check("h_redir_inst_valid_fall", inst_valid, 0);
      check("h_redir_req_valid", imem_req_valid, 1);
      check("h_redir_addr", imem_req_addr, 32'h8000_0200);

      // Misaligned redirect in FETCH while the request is accepted.
      redirect_valid  = 1'b1;
      redirect_target = 32'h8000_0102;
      cycle();
      redirect_valid = 1'b0;
      check("mis_pulse", misalign_err, 1);
      check("mis_drop_req_valid", imem_req_valid, 0);
      cycle();
      check("mis_not_sticky", misalign_err, 0);
      check("mis_req_valid", imem_req_valid, 1);
      check("mis_addr", imem_req_addr, 32'h8000_0100);

      // Decode stalls 10 cycles in HOLD; a spurious response is ignored.
      inst_ready = 1'b0;
      push_exp(32'h8000_0100);
      cycle();
      cycle();
      check("stallh_inst_valid", inst_valid, 1);
      check("stallh_inst_pc", inst_pc, 32'h8000_0100);
      held_inst = mem_data(32'h8000_0100);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
         end
         cycle();
         check("stallh_valid", inst_valid, 1);
         check("stallh_inst", inst, held_inst);
         check("stallh_pc", inst_pc, 32'h8000_0100);
         check("stallh_no_req", imem_req_valid, 0);
      end
      inst_ready = 1'b1;
      cycle();
      check("sb_drained_1", exp_q.size(), 0);
      check("post_stall_addr", imem_req_addr, 32'h8000_0104);
      check("post_stall_req_valid", imem_req_valid, 1);

      // Reset asserted mid-HOLD, then refetch from the reset PC.
      inst_ready = 1'b0;
      cycle();
      cycle();
      check("pre_rst_inst_valid", inst_valid, 1);
      check("pre_rst_inst_pc", inst_pc, 32'h8000_0104);
      rst = 1'b1;
      cycle();
      check("mid_rst_inst_valid", inst_valid, 0);
      check("mid_rst_req_valid", imem_req_valid, 0);
      check("mid_rst_inst", inst, 0);
      check("mid_rst_inst_pc", inst_pc, 0);
      check("mid_rst_addr", imem_req_addr, 32'h8000_0000);
      rst = 1'b0;
      cycle();
      check("refetch_req_valid", imem_req_valid, 1);
      check("refetch_addr", imem_req_addr, 32'h8000_0000);
      inst_ready = 1'b1;
      push_exp(32'h8000_0000);
      wait_consumed("refetch_consumed", 10);

      // Redirect in FETCH with request not accepted: address changes in place.
      imem_req_ready  = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h8000_0300;
      cycle();
      check("f_redir_req_valid", imem_req_valid, 1);
      check("f_redir_addr", imem_req_addr, 32'h8000_0300);

      // Misaligned redirect to the top of the address space, then wrap.
      redirect_target = 32'hFFFF_FFFE;
      cycle();
      redirect_valid = 1'b0;
      check("top_addr", imem_req_addr, 32'hFFFF_FFFC);
      check("top_misalign", misalign_err, 1);
      imem_req_ready = 1'b1;
      push_exp(32'hFFFF_FFFC);
      wait_consumed("top_consumed", 10);
      check("wrap_req_valid", imem_req_valid, 1);
      check("wrap_addr", imem_req_addr, 32'h0000_0000);
      check("sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
